wb_stage: RTL

Writeback stage for the 8-bit core, directly upstream of the register file. Accepts one retiring instruction per cycle from execute, performs the data-memory read for loads over a req/ack handshake with timeout, and drives the register file's write port and r1 flag-write port. Holds execute with `wb_busy` while a load is outstanding.

---
 rtl/core_pkg.sv | 22 ++
 rtl/wb_timeout_ctr.sv | 39 +++
 rtl/wb_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the 8-bit core pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_R0   = 0;
    localparam int REG_FLAG = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
// ============================================================================
// Module      : wb_timeout_ctr
// Description : Cycle counter for the load request phase; hit flags the
//               TIMEOUT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_ctr
    import core_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count starts at 0 in the first enabled cycle, so TIMEOUT-1 marks the last one.
    assign o_hit = i_en && (r_count == c_LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage: retires ALU results directly and performs
//               load reads over a req/ack handshake with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import core_pkg::*;
#(
    parameter int PW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [PW:0]       ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_flag,
    input  logic              ex_flag_en,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_mem_addr,
    output logic              wb_busy,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rf_dat,
    output logic              rf_wr_en,
    output logic [PW:0]       rf_wr_addr,
    output logic              rf_flag,
    output logic              rf_flag_en,
    output logic              wb_err
);

    localparam logic [PW:0] c_R0   = (PW + 1)'(REG_R0);
    localparam logic [PW:0] c_FLAG = (PW + 1)'(REG_FLAG);

    // r0 and the flag register are never written through the data port.
    function automatic logic is_gp_reg(input logic [PW:0] rd);
        return (rd != c_R0) && (rd != c_FLAG);
    endfunction

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;

    logic              w_busy;
    logic              w_req;
    logic              w_alu_accept;
    logic              w_ld_accept;
    logic              w_ack;
    logic              w_timeout;
    logic              w_hit;

    logic [PW:0]       r_ld_rd;
    logic              r_ld_wr;
    logic [DATA_W-1:0] r_mem_addr;
    logic              r_err;
    logic [DATA_W-1:0] r_rf_dat;
    logic              r_rf_wr_en;
    logic [PW:0]       r_rf_wr_addr;
    logic              r_rf_flag;
    logic              r_rf_flag_en;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .i_clr (r_state != REQ),
        .i_en  (r_state == REQ),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_busy       = 1'b1;
        w_req        = 1'b0;
        w_alu_accept = 1'b0;
        w_ld_accept  = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy       = 1'b0;
                w_alu_accept = ex_valid && !ex_is_load;
                w_ld_accept  = ex_valid && ex_is_load;
                if (w_ld_accept) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_req = 1'b1;
                // An ack arriving on the final allowed cycle still completes the load.
                if (mem_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = WRITE;
                end else if (w_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_rd      <= '0;
            r_ld_wr      <= 1'b0;
            r_mem_addr   <= '0;
            r_err        <= 1'b0;
            r_rf_dat     <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_flag    <= 1'b0;
            r_rf_flag_en <= 1'b0;
        end else begin
            r_rf_dat     <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_flag    <= 1'b0;
            r_rf_flag_en <= 1'b0;
            if (w_alu_accept) begin
                r_rf_dat     <= ex_result;
                r_rf_wr_addr <= ex_rd;
                r_rf_wr_en   <= ex_reg_wr && is_gp_reg(ex_rd);
                r_rf_flag    <= ex_flag;
                r_rf_flag_en <= ex_flag_en;
            end
            if (w_ld_accept) begin
                r_ld_rd    <= ex_rd;
                r_ld_wr    <= ex_reg_wr;
                r_mem_addr <= ex_mem_addr;
            end
            // Load data lands in the output registers so it is visible during WRITE.
            if (w_ack) begin
                r_rf_dat     <= mem_rdata;
                r_rf_wr_addr <= r_ld_rd;
                r_rf_wr_en   <= r_ld_wr && is_gp_reg(r_ld_rd);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wb_busy    = w_busy;
    assign mem_req    = w_req;
    assign mem_addr   = r_mem_addr;
    assign rf_dat     = r_rf_dat;
    assign rf_wr_en   = r_rf_wr_en;
    assign rf_wr_addr = r_rf_wr_addr;
    assign rf_flag    = r_rf_flag;
    assign rf_flag_en = r_rf_flag_en;
    assign wb_err     = r_err;

endmodule

`default_nettype wire
